// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch controller in front of a UART transmitter.
// Bytes written through wr_en/wr_data are buffered and handed to the transmitter
// one at a time over a start/data/ready handshake. tx_data is held stable from
// launch until the transmitter reports ready again.
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   wr_en     in   write strobe, accepted when full = 0
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds 2**DEPTH_LOG2 bytes
//   count     out  stored bytes, not counting the byte in flight
//   overflow  out  one-cycle pulse for a write rejected because of full
//   tx_start  out  one-cycle launch pulse to the transmitter
//   tx_data   out  byte presented to the transmitter
//   tx_ready  in   transmitter idle (1) / busy (0)
//   idle      out  FIFO empty, controller idle and transmitter ready
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  idle
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [2:0] S_SYNC      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  idle_q, idle_d;
    logic [7:0]            mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    // Next-state, FIFO bookkeeping and registered output values
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        push       = wr_en && !full_q;

        case (state_q)
            // Transmitter has no reset and may still be finishing a frame
            S_SYNC: begin
                if (tx_ready) state_d = S_IDLE;
            end
            S_IDLE: begin
                if ((count_q != '0) && tx_ready) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    state_d    = S_START;
                end
            end
            // Transmitter only drops ready a cycle after sampling start
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d     = (count_d == CW'(DEPTH));
        overflow_d = wr_en && full_q;
        idle_d     = (count_d == '0) && (state_d == S_IDLE) && tx_ready;
    end

    // Control and output registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SYNC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            idle_q     <= idle_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign idle     = idle_q;

endmodule
